// File: rtl/rx_sync_pkg.sv
// Shared state encoding and default OFDM symbol geometry for the rx sync sequencer.
package rx_sync_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        FEST    = 3'd2,
        FINE    = 3'd3,
        TRACK   = 3'd4,
        RESTART = 3'd5
    } rx_state_e;

    localparam int unsigned FFT_LEN        = 2048;
    localparam int unsigned CP_LEN         = 512;
    localparam int unsigned SYM_LEN_802_22 = FFT_LEN + CP_LEN;

endpackage

// File: rtl/rx_sync_ctrl_sample_cnt.sv
// Valid-gated sample counter with synchronous clear and terminal-count detect.
// The count wraps to zero on its terminal sample, so it never exceeds lim-1.
module sample_cnt #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          valid,
    input  logic [CW-1:0] lim,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] lim_m1;

    assign lim_m1 = lim - CW'(1);
    assign tc     = valid & (cnt_q == lim_m1);
    assign cnt    = cnt_q;

    // Next count: clear dominates, otherwise advance on valid samples and wrap at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (valid) begin
            if (cnt_q == lim_m1) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Acquisition/tracking sequencer for the 802.22 OFDM receiver front end.
// Sequences search -> freq-offset estimation -> fine timing -> frame tracking,
// restarting the search whenever a stage times out or a frame completes.
module rx_sync_ctrl
    import rx_sync_pkg::*;
#(
    parameter int unsigned   CW       = 16,
    parameter logic [CW-1:0] SRCH_TMO = 16'd40960,
    parameter logic [CW-1:0] FEST_LEN = 16'd1024,
    parameter logic [CW-1:0] FINE_TMO = 16'd2560,
    parameter logic [CW-1:0] SYM_LEN  = CW'(SYM_LEN_802_22),
    parameter logic [CW-1:0] N_SYM    = 16'd16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          coarse_det,
    input  logic          fine_det,
    output logic          metric_ena,
    output logic          coarse_cyc,
    output logic          freoff_ena,
    output logic          fine_ena,
    output logic          frm_active,
    output logic          sym_start,
    output logic [CW-1:0] sym_idx,
    output logic          sync_lost,
    output logic [2:0]    state_o
);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] sym_idx_q, sym_idx_d;

    logic          metric_ena_q, metric_ena_d;
    logic          coarse_cyc_q, coarse_cyc_d;
    logic          freoff_ena_q, freoff_ena_d;
    logic          fine_ena_q, fine_ena_d;
    logic          frm_active_q, frm_active_d;
    logic          sync_lost_q, sync_lost_d;
    logic [2:0]    state_o_q, state_o_d;

    logic          valid;
    logic          timeout;
    logic          cnt_clr;
    logic [CW-1:0] cnt_lim;
    logic [CW-1:0] cnt;
    logic          cnt_tc;

    assign valid = cyc_i & stb_i;

    // One counter serves every stage; its limit follows the current state.
    always_comb begin
        cnt_lim = SRCH_TMO;
        case (state_q)
            SEARCH:  cnt_lim = SRCH_TMO;
            FEST:    cnt_lim = FEST_LEN;
            FINE:    cnt_lim = FINE_TMO;
            TRACK:   cnt_lim = SYM_LEN;
            default: cnt_lim = SRCH_TMO;
        endcase
    end

    // Count restarts on every state change and is held at zero while idle or restarting.
    assign cnt_clr = (state_d != state_q) || (state_q == IDLE) || (state_q == RESTART);

    sample_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .valid (valid),
        .lim   (cnt_lim),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // Next-state, symbol index and timeout decode; losing cyc_i overrides everything.
    always_comb begin
        state_d   = state_q;
        sym_idx_d = '0;
        timeout   = 1'b0;
        if (!cyc_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                end
                SEARCH: begin
                    if (coarse_det) begin
                        state_d = FEST;
                    end else if (cnt_tc) begin
                        state_d = RESTART;
                        timeout = 1'b1;
                    end
                end
                FEST: begin
                    if (cnt_tc) begin
                        state_d = FINE;
                    end
                end
                FINE: begin
                    if (fine_det) begin
                        state_d = TRACK;
                    end else if (cnt_tc) begin
                        state_d = RESTART;
                        timeout = 1'b1;
                    end
                end
                TRACK: begin
                    sym_idx_d = sym_idx_q;
                    if (cnt_tc) begin
                        if (sym_idx_q == N_SYM - CW'(1)) begin
                            state_d   = RESTART;
                            sym_idx_d = '0;
                        end else begin
                            sym_idx_d = sym_idx_q + CW'(1);
                        end
                    end
                end
                RESTART: begin
                    state_d = SEARCH;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode from the current state; registered so outputs trail the state by one cycle.
    always_comb begin
        metric_ena_d = (state_q == SEARCH);
        freoff_ena_d = (state_q == FEST);
        fine_ena_d   = (state_q == FINE);
        frm_active_d = (state_q == TRACK);
        coarse_cyc_d = (state_q == SEARCH) || (state_q == FEST) ||
                       (state_q == FINE)   || (state_q == TRACK);
        sync_lost_d  = timeout;
        state_o_d    = state_q;
    end

    // State, symbol index and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sym_idx_q    <= '0;
            metric_ena_q <= 1'b0;
            coarse_cyc_q <= 1'b0;
            freoff_ena_q <= 1'b0;
            fine_ena_q   <= 1'b0;
            frm_active_q <= 1'b0;
            sync_lost_q  <= 1'b0;
            state_o_q    <= '0;
        end else begin
            state_q      <= state_d;
            sym_idx_q    <= sym_idx_d;
            metric_ena_q <= metric_ena_d;
            coarse_cyc_q <= coarse_cyc_d;
            freoff_ena_q <= freoff_ena_d;
            fine_ena_q   <= fine_ena_d;
            frm_active_q <= frm_active_d;
            sync_lost_q  <= sync_lost_d;
            state_o_q    <= state_o_d;
        end
    end

    assign sym_start  = (state_q == TRACK) & valid & (cnt == '0);
    assign metric_ena = metric_ena_q;
    assign coarse_cyc = coarse_cyc_q;
    assign freoff_ena = freoff_ena_q;
    assign fine_ena   = fine_ena_q;
    assign frm_active = frm_active_q;
    assign sync_lost  = sync_lost_q;
    assign sym_idx    = sym_idx_q;
    assign state_o    = state_o_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Scoreboard bench for rx_sync_ctrl: directed scenarios followed by random stimulus,
// with expected outputs from a sample-counting reference model.
module tb_rx_sync_ctrl;

    localparam int CW       = 16;
    localparam int SRCH_TMO = 16;
    localparam int FEST_LEN = 8;
    localparam int FINE_TMO = 12;
    localparam int SYM_LEN  = 10;
    localparam int N_SYM    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc_i = 1'b0;
    logic          stb_i = 1'b0;
    logic          coarse_det = 1'b0;
    logic          fine_det = 1'b0;
    logic          metric_ena, coarse_cyc, freoff_ena, fine_ena, frm_active;
    logic          sym_start, sync_lost;
    logic [CW-1:0] sym_idx;
    logic [2:0]    state_o;

    rx_sync_ctrl #(
        .CW       (CW),
        .SRCH_TMO (16'(SRCH_TMO)),
        .FEST_LEN (16'(FEST_LEN)),
        .FINE_TMO (16'(FINE_TMO)),
        .SYM_LEN  (16'(SYM_LEN)),
        .N_SYM    (16'(N_SYM))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cyc_i      (cyc_i),
        .stb_i      (stb_i),
        .coarse_det (coarse_det),
        .fine_det   (fine_det),
        .metric_ena (metric_ena),
        .coarse_cyc (coarse_cyc),
        .freoff_ena (freoff_ena),
        .fine_ena   (fine_ena),
        .frm_active (frm_active),
        .sym_start  (sym_start),
        .sym_idx    (sym_idx),
        .sync_lost  (sync_lost),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Field order: metric coarse_cyc freoff fine frm sym_start sync_lost state[3] sym_idx[16]
    logic [25:0] got_v;
    assign got_v = {metric_ena, coarse_cyc, freoff_ena, fine_ena, frm_active,
                    sym_start, sync_lost, state_o, sym_idx};

    logic [25:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          end_req = 1'b0;
    bit          end_done = 1'b0;

    // Reference model: current state, samples seen in that state, and registered outputs.
    int m_st = 0;
    int m_n  = 0;
    bit r_met = 0, r_cc = 0, r_fre = 0, r_fin = 0, r_frm = 0, r_lost = 0;
    int r_st = 0;

    task automatic model_step(input bit c, input bit s, input bit cd, input bit fd,
                              input bit r, output logic [25:0] e);
        bit v;
        bit lost;
        bit ss;
        int idx;
        int nst;
        int nn;
        v = c & s;
        if (!r) begin
            m_st = 0; m_n = 0;
            r_met = 0; r_cc = 0; r_fre = 0; r_fin = 0; r_frm = 0; r_lost = 0; r_st = 0;
            e = '0;
            return;
        end
        ss  = (m_st == 4) && v && ((m_n % SYM_LEN) == 0);
        idx = (m_st == 4) ? (m_n / SYM_LEN) : 0;
        e = {r_met, r_cc, r_fre, r_fin, r_frm, ss, r_lost, 3'(r_st), 16'(idx)};

        lost = 0; nst = m_st; nn = m_n;
        if (!c) begin
            nst = 0; nn = 0;
        end else begin
            case (m_st)
                0: begin nst = 1; nn = 0; end
                1: if (cd) begin nst = 2; nn = 0; end
                   else if (v) begin
                       if (m_n + 1 == SRCH_TMO) begin nst = 5; nn = 0; lost = 1; end
                       else nn = m_n + 1;
                   end
                2: if (v) begin
                       if (m_n + 1 == FEST_LEN) begin nst = 3; nn = 0; end
                       else nn = m_n + 1;
                   end
                3: if (fd) begin nst = 4; nn = 0; end
                   else if (v) begin
                       if (m_n + 1 == FINE_TMO) begin nst = 5; nn = 0; lost = 1; end
                       else nn = m_n + 1;
                   end
                4: if (v) begin
                       if (m_n + 1 == N_SYM * SYM_LEN) begin nst = 5; nn = 0; end
                       else nn = m_n + 1;
                   end
                default: begin nst = (m_st == 5) ? 1 : 0; nn = 0; end
            endcase
        end
        r_met  = (m_st == 1);
        r_fre  = (m_st == 2);
        r_fin  = (m_st == 3);
        r_frm  = (m_st == 4);
        r_cc   = (m_st >= 1) && (m_st <= 4);
        r_lost = lost;
        r_st   = m_st;
        m_st   = nst;
        m_n    = nn;
    endtask

    task automatic step(input bit c, input bit s, input bit cd, input bit fd, input bit r);
        logic [25:0] e;
        @(posedge clk);
        #1;
        rst_n      = r;
        cyc_i      = c;
        stb_i      = s;
        coarse_det = cd;
        fine_det   = fd;
        model_step(c, s, cd, fd, r, e);
        sb_q.push_back(e);
    endtask

    task automatic run(input int n, input bit c, input bit s, input bit cd, input bit fd);
        for (int i = 0; i < n; i++) step(c, s, cd, fd, 1'b1);
    endtask

    // Monitor: compare every presented output vector against the queued expectation.
    always @(negedge clk) begin
        logic [25:0] exp_v;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%b required=%b (met cc fre fin frm ss lost st idx)",
                         $time, got_v, exp_v);
            end
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
            end
        end
    end

    initial begin
        // Reset held, then search timeout with continuous samples.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        run(2, 0, 0, 0, 0);
        run(20, 1, 1, 0, 0);
        // Acquisition: coarse_det on sample 5, gapped FEST, fine_det on FINE sample 3, tracking.
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        run(4, 1, 1, 0, 0);
        step(1, 1, 1, 0, 1);
        for (int i = 0; i < 16; i++) step(1, (i % 2) == 0, 0, 0, 1);
        run(3, 1, 1, 0, 0);
        step(1, 1, 0, 1, 1);
        run(25, 1, 1, 0, 0);
        // Simultaneous terminal-sample events.
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        run(15, 1, 1, 0, 0);
        step(1, 1, 1, 0, 1);
        run(8, 1, 1, 0, 0);
        run(11, 1, 1, 0, 0);
        step(1, 1, 0, 1, 1);
        run(7, 1, 1, 0, 0);
        // Asynchronous reset mid-TRACK, then release with cyc_i high.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        run(4, 1, 1, 0, 0);
        // Abort during FEST.
        step(1, 1, 1, 0, 1);
        run(3, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1);
        run(6, 1, 1, 0, 0);
        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        end_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_sync_ctrl.md
Name: rx_sync_ctrl

Overview:
- Acquisition and tracking sequencer for the 802.22 OFDM receiver front end.
- Enables the P/R metric and coarse time synch datapath, then runs frequency-offset estimation and fine timing.
- Tracks symbol boundaries for one frame and forces a re-search when a stage times out.
- Sits between the input sample bus (cyc_i/stb_i) and the enable/cyc inputs of the metric, coarse-sync, freq-offset and fine-sync blocks.

Parameters:
- CW, 16, width of all sample counters.
- SRCH_TMO, 16'd40960, valid samples allowed in SEARCH before restart.
- FEST_LEN, 16'd1024, valid samples the freq-offset estimator is enabled for.
- FINE_TMO, 16'd2560, valid samples allowed in FINE before restart.
- SYM_LEN, 16'd2560, samples per symbol (2048 FFT + 512 CP).
- N_SYM, 16'd16, symbols per frame tracked in TRACK.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cyc_i  in  1  burst active from the upstream sample source.
- stb_i  in  1  sample valid; a sample counts only when cyc_i & stb_i.
- coarse_det  in  1  level from coarse time synch; plateau detected.
- fine_det  in  1  single-cycle pulse from fine time synch; symbol 0 boundary found.
- metric_ena  out  1  enable for the P/R metric and the coarse-sync ena input.
- coarse_cyc  out  1  cyc to coarse time synch; low for one cycle clears its internal state.
- freoff_ena  out  1  freq-offset estimator enable.
- fine_ena  out  1  fine time synch enable.
- frm_active  out  1  high throughout TRACK.
- sym_start  out  1  one-cycle pulse on the first valid sample of each symbol in TRACK.
- sym_idx  out  CW  index of the current symbol in TRACK.
- sync_lost  out  1  one-cycle pulse on any timeout.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset: async assert on rst_n low. Every output is 0, state is IDLE, all counters are 0.
- Outputs are registered and decoded from the state; they change one cycle after a transition.
- "Valid" below means cyc_i & stb_i. Counters advance only on valid samples.
- Global abort: cyc_i low in any state goes to IDLE next cycle, counters clear, no sync_lost. This has top priority.
- IDLE (0): all outputs low. When cyc_i is high, go to SEARCH.
- SEARCH (1):
  - metric_ena=1, coarse_cyc=1; cnt counts valid samples.
  - coarse_det high: go to FEST, cnt cleared. This has priority over timeout in the same cycle.
  - Else a valid sample with cnt==SRCH_TMO-1: go to RESTART, pulse sync_lost.
- FEST (2):
  - freoff_ena=1, coarse_cyc=1, metric_ena=0.
  - On the valid sample with cnt==FEST_LEN-1: go to FINE, cnt cleared.
- FINE (3):
  - fine_ena=1, freoff_ena=0, coarse_cyc=1.
  - fine_det: go to TRACK with cnt=0 and sym_idx=0. This has priority over timeout.
  - Else a valid sample with cnt==FINE_TMO-1: go to RESTART, pulse sync_lost.
- TRACK (4):
  - frm_active=1, coarse_cyc=1.
  - cnt counts samples modulo SYM_LEN: it wraps from SYM_LEN-1 to 0 and sym_idx increments on the wrap.
  - sym_start is asserted in the same cycle as a valid sample with cnt==0 (combinational from the registered count, AND-ed with valid).
  - On the wrap where sym_idx==N_SYM-1: go to RESTART with no sync_lost, and sym_idx clears.
- RESTART (5):
  - Lasts exactly one cycle; all enables low and coarse_cyc=0, which clears the coarse-sync block.
  - Next state is SEARCH, or IDLE if cyc_i is low.
- fine_det outside FINE and coarse_det outside SEARCH are ignored.
- Counters never exceed their terminal values, with no wrap beyond the parameter. Unused encodings 6/7 go to IDLE.

Decomposition:
- Package rx_sync_pkg holds:
  - the state localparams IDLE..RESTART (3-bit);
  - the default lengths SYM_LEN_802_22=2560, FFT_LEN=2048, CP_LEN=512.
- One sub-module, sample_cnt:
  - CW-bit counter with clr, valid-gated inc, and a terminal-count compare against an input limit, giving tc = valid & (cnt==lim-1).
  - Instantiated once and shared across states; the limit is muxed by state.

Test Plan (SRCH_TMO=16, FEST_LEN=8, FINE_TMO=12, SYM_LEN=10, N_SYM=2):
- Reset: rst_n low mid-TRACK, async. All outputs go 0 immediately; after release with cyc_i=1, state_o=1 two edges later.
- Search timeout: cyc_i=stb_i=1, coarse_det=0 for 16 samples. sync_lost pulses once, coarse_cyc is low for exactly 1 cycle, then SEARCH resumes and the count restarts at 0.
- Acquisition:
  - coarse_det on sample 5: freoff_ena is high for exactly 8 valid samples, with stb_i gaps inserted that must not count.
  - Then fine_ena=1; fine_det on FINE sample 3 enters TRACK.
- Tracking:
  - In TRACK, with continuous stb_i, sym_start pulses on samples 0 and 10 with sym_idx 0 and 1.
  - At sample 20, RESTART occurs without sync_lost.
- Simultaneous events:
  - coarse_det on the SRCH_TMO-1 sample: enter FEST, no sync_lost.
  - fine_det on the FINE_TMO-1 sample: enter TRACK.
- Abort: cyc_i dropped during FEST. IDLE next cycle, all enables 0, no sync_lost; raising cyc_i again restarts SEARCH with cnt=0.
